ldw_mem_stage: RTL

Memory stage of the ldw five-stage pipeline. It consumes the EX/MEM register outputs, performs word loads/stores over a req/ack data-memory bus that may take several cycles, and holds the MEM/WB pipeline register. While a bus access is outstanding, it stalls the upstream pipeline and inserts bubbles into writeback.

---
 rtl/ldw_mem_pkg.sv | 19 +
 rtl/ldw_mw_reg.sv | 18 +
 rtl/ldw_mem_stage.sv | 106 ++++++++++
 3 files changed

// File: rtl/ldw_mem_pkg.sv
// Shared types and constants for the ldw memory stage: FSM encoding, timeout default, MEM/WB bundle.
package ldw_mem_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  localparam int DEF_TIMEOUT = 255;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic [31:0] mo;
    logic [31:0] alu;
    logic [4:0]  rn;
  } mw_t;

  localparam mw_t MW_BUBBLE = '0;

endpackage

// File: rtl/ldw_mw_reg.sv
// MEM/WB pipeline register; loads every cycle, or a bubble when bubble=1.
// Latency 1; no backpressure (writeback always accepts).
module ldw_mw_reg
  import ldw_mem_pkg::*;
(
  input  logic clk,
  input  logic clrn,
  input  logic bubble,
  input  mw_t  d,
  output mw_t  q
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) q <= MW_BUBBLE;
    else       q <= bubble ? MW_BUBBLE : d;
  end

endmodule

// File: rtl/ldw_mem_stage.sv
// ldw MEM stage: word load/store over a req/ack bus with timeout, plus MEM/WB register.
// Latency 1 for non-memory ops, N+2 for memory ops; stalls upstream while the bus is outstanding.
module ldw_mem_stage
  import ldw_mem_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [4:0]  mrn,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_we,
  output logic        dmem_req,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn,
  output logic        mem_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic       state;
  logic [7:0] cnt;
  logic       memop, misal, busy, start, done, abort, err_now, hold;
  mw_t        mw_d, mw_q;

  always_comb begin
    memop   = mm2reg | mwmem;
    misal   = |malu[1:0];
    busy    = (state == ST_BUSY);
    start   = !busy && memop && !misal;
    done    = busy && dmem_ack;
    abort   = busy && !dmem_ack && (cnt == CNT_LAST);
    err_now = (!busy && memop && misal) || abort;
    hold    = start || (busy && !dmem_ack && !abort);
  end

  // Gated by clrn so nothing upstream is held while the stage is in reset.
  assign stall_mem = clrn & hold;

  // A failed access keeps its fields but loses its register write.
  always_comb begin
    mw_d       = MW_BUBBLE;
    mw_d.wreg  = mwreg & ~err_now;
    mw_d.m2reg = mm2reg;
    mw_d.mo    = (done && mm2reg) ? dmem_rdata : 32'd0;
    mw_d.alu   = malu;
    mw_d.rn    = mrn;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= ST_IDLE;
      cnt        <= 8'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      mem_err    <= 1'b0;
    end else begin
      mem_err <= err_now;
      if (!busy) begin
        if (start) begin
          state      <= ST_BUSY;
          cnt        <= 8'd0;
          dmem_req   <= 1'b1;
          dmem_addr  <= malu;
          dmem_wdata <= mb;
          dmem_we    <= mwmem & ~mm2reg;
        end
      end else if (done || abort) begin
        state    <= ST_IDLE;
        dmem_req <= 1'b0;
        dmem_we  <= 1'b0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  ldw_mw_reg u_mw_reg (
    .clk    (clk),
    .clrn   (clrn),
    .bubble (hold),
    .d      (mw_d),
    .q      (mw_q)
  );

  assign wwreg  = mw_q.wreg;
  assign wm2reg = mw_q.m2reg;
  assign wmo    = mw_q.mo;
  assign walu   = mw_q.alu;
  assign wrn    = mw_q.rn;

endmodule
